// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a two-entry skid buffer and synchronous flush.
// Define IMMX_PERF_EN to add the saturating output-transfer counter port perf_count.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:IN_W-1]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [0:TAG_W-1] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:OUT_W-1] out_data,
    output logic [0:TAG_W-1] out_tag
`ifdef IMMX_PERF_EN
    ,
    output logic [0:15]      perf_count
`endif
);

    localparam int PAD = OUT_W - IN_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic [OUT_W-1:0] sx;
        sx = {{PAD{imm[IN_W-1]}}, imm};
        case (mode)
            MODE_ZERO:  extend = {{PAD{1'b0}}, imm};
            MODE_SIGN:  extend = sx;
            MODE_UPPER: extend = {imm, {PAD{1'b0}}};
            default:    extend = {sx[OUT_W-3:0], 2'b00};
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic [OUT_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic [OUT_W-1:0] ext_val;
    logic [TAG_W-1:0] tag_val;
    logic             accept, pop;

    assign ext_val   = extend(in_imm, in_mode);
    assign tag_val   = in_tag;
    // An input offered during flush is squashed along with the buffered entries.
    assign accept    = in_valid & ready_q & ~flush;
    assign out_valid = (state_q != ST_EMPTY);
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = ext_val;
                        main_tag_d  = tag_val;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d     = ST_TWO;
                        skid_data_d = ext_val;
                        skid_tag_d  = tag_val;
                    end else if (accept && pop) begin
                        main_data_d = ext_val;
                        main_tag_d  = tag_val;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_tag_d  = skid_tag_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign in_ready = ready_q;
    assign out_data = main_data_q;
    assign out_tag  = main_tag_q;

`ifdef IMMX_PERF_EN
    logic [15:0] count_q, count_d;

    // Flush wins over a coincident pop, so the counter ends at zero.
    always_comb begin
        count_d = count_q;
        if (flush) count_d = '0;
        else if (pop) count_d = sat_inc(count_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign perf_count = count_q;
`endif

endmodule
